// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8-bit UART transmitter, 1 start bit, LSB first, 1 stop bit.
// Optional even parity bit after bit 7 when UART_TX_PARITY_EN is defined.
// Frames queued in the FIFO go out back to back with no idle gap.
module uart_tx #(
   parameter int unsigned BAUD       = 434,
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic       transmit,
   input  logic [7:0] data_tx,
   output logic       busy_tx,
   output logic       full,
   output logic       overflow,
   output logic       tx
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = $clog2(BAUD);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD - 1);
   localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_TX_PARITY_EN
      StParity,
`endif
      StStop
   } state_e;

   // FIFO storage and bookkeeping
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q;
   logic                  push, pop;
   logic [7:0]            head;

   // Transmit engine
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   assign full     = (count_q == COUNT_FULL);
   assign push     = transmit & ~full;
   assign head     = mem[rd_ptr_q];
   assign overflow = overflow_q;
   assign tx       = tx_q;
   assign busy_tx  = (state_q != StIdle) | (count_q != '0);
   assign bit_end  = (cnt_q == CNT_MAX);

   // FIFO occupancy: push and pop on the same edge leave the count unchanged
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO data array; deliberately unreset since it is never read while empty
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= data_tx;
      end
   end

   // FIFO pointers, count and sticky overflow flag
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q    <= count_d;
         // A write while full is dropped even if a pop frees a slot on this edge
         overflow_q <= overflow_q | (transmit & full);
      end
   end

   // Transmit FSM next-state, bit timing and line value
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      if (state_q != StIdle) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               cnt_d   = '0;
               state_d = StStart;
`ifdef UART_TX_PARITY_EN
               parity_d = ^head;
`endif
            end
         end
         StStart: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = StParity;
`else
                  tx_d    = 1'b1;
                  state_d = StStop;
`endif
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               tx_d    = 1'b1;
               state_d = StStop;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               // Chain straight into the next start bit when more data is queued
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = StStart;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^head;
`endif
               end else begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // Transmit FSM state register; reset abandons any frame and idles the line high
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: BAUD=4 instance for function, BAUD=434 instance for timing.
// Honours UART_TX_PARITY_EN to expect 11-bit frames.
module tb_uart_tx;

   localparam int BAUD   = 4;
   localparam int BAUD_S = 434;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int F   = FRAME_BITS * BAUD;
   localparam int F_S = FRAME_BITS * BAUD_S;

   logic       clk;
   logic       nRst;
   logic       transmit, transmit_s;
   logic [7:0] data_tx, data_s;
   logic       busy_tx, full, overflow, tx;
   logic       busy_s, full_s, overflow_s, tx_s;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_bytes [6];
   int         exp_n;

   uart_tx #(.BAUD(BAUD), .DEPTH_LOG2(2)) dut (
      .clk      (clk),
      .nRst     (nRst),
      .transmit (transmit),
      .data_tx  (data_tx),
      .busy_tx  (busy_tx),
      .full     (full),
      .overflow (overflow),
      .tx       (tx)
   );

   uart_tx #(.BAUD(BAUD_S), .DEPTH_LOG2(2)) dut_s (
      .clk      (clk),
      .nRst     (nRst),
      .transmit (transmit_s),
      .data_tx  (data_s),
      .busy_tx  (busy_s),
      .full     (full_s),
      .overflow (overflow_s),
      .tx       (tx_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line value of bit i within a frame carrying d
   function automatic logic frame_bit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
      if (FRAME_BITS == 11 && i == 9) return ^d;
      return 1'b1;
   endfunction

   // Expected line value c cycles after the first start bit of exp_bytes
   function automatic logic stream_bit(input int c, input int baud);
      int flen = FRAME_BITS * baud;
      int f    = c / flen;
      int b    = (c % flen) / baud;
      if (f >= exp_n) return 1'b1;
      return frame_bit(exp_bytes[f], b);
   endfunction

   task automatic do_reset();
      nRst       = 1'b0;
      transmit   = 1'b0;
      transmit_s = 1'b0;
      repeat (2) @(negedge clk);
      nRst = 1'b1;
   endtask

   task automatic test_reset();
      nRst       = 1'b0;
      transmit   = 1'b0;
      transmit_s = 1'b0;
      data_tx    = 8'h00;
      data_s     = 8'h00;
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      checks++;
      if (busy_tx !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", busy_tx);
      end
      checks++;
      if (full !== 1'b0) begin
         errors++; $display("FAIL reset_full: got %b want 0", full);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow: got %b want 0", overflow);
      end
      @(negedge clk);
      nRst = 1'b1;
   endtask

   // Single 0x55: start bit one cycle after the accepting edge, busy ends after one frame
   task automatic test_single();
      logic e;
      exp_bytes[0] = 8'h55;
      exp_n        = 1;
      for (int n = 0; n <= F + 2; n++) begin
         @(negedge clk);
         e = (n < 2) ? 1'b1 : stream_bit(n - 2, BAUD);
         checks++;
         if (tx !== e) begin
            errors++; $display("FAIL single_tx n=%0d: got %b want %b", n, tx, e);
         end
         e = (n >= 1 && n <= F + 1);
         checks++;
         if (busy_tx !== e) begin
            errors++; $display("FAIL single_busy n=%0d: got %b want %b", n, busy_tx, e);
         end
         transmit = (n == 0);
         data_tx  = 8'h55;
      end
   endtask

   // Five writes on consecutive cycles into an empty FIFO: all accepted, no gaps
   task automatic test_back_to_back();
      logic e;
      for (int i = 0; i < 5; i++) exp_bytes[i] = 8'(i + 1);
      exp_n = 5;
      for (int n = 0; n <= 5 * F + 2; n++) begin
         @(negedge clk);
         e = (n < 2) ? 1'b1 : stream_bit(n - 2, BAUD);
         checks++;
         if (tx !== e) begin
            errors++; $display("FAIL b2b_tx n=%0d: got %b want %b", n, tx, e);
         end
         if (n == 4 || n == 5) begin
            e = (n == 5);
            checks++;
            if (full !== e) begin
               errors++; $display("FAIL b2b_full n=%0d: got %b want %b", n, full, e);
            end
         end
         transmit = (n < 5);
         data_tx  = 8'(n + 1);
      end
      checks++;
      if (busy_tx !== 1'b0) begin
         errors++; $display("FAIL b2b_busy_end: got %b want 0", busy_tx);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL b2b_overflow: got %b want 0", overflow);
      end
   endtask

   // Six writes while a frame is running: four queued, the rest dropped with overflow
   task automatic test_overflow();
      logic e;
      do_reset();
      exp_bytes[0] = 8'hA0;
      exp_bytes[1] = 8'hB1;
      exp_bytes[2] = 8'hB2;
      exp_bytes[3] = 8'hB3;
      exp_bytes[4] = 8'hB4;
      exp_n        = 5;
      for (int n = 0; n <= 5 * F + 2; n++) begin
         @(negedge clk);
         e = (n < 2) ? 1'b1 : stream_bit(n - 2, BAUD);
         checks++;
         if (tx !== e) begin
            errors++; $display("FAIL ovf_tx n=%0d: got %b want %b", n, tx, e);
         end
         if (n == 6) begin
            checks++;
            if (full !== 1'b1) begin
               errors++; $display("FAIL ovf_full: got %b want 1", full);
            end
            checks++;
            if (overflow !== 1'b0) begin
               errors++; $display("FAIL ovf_early: got %b want 0", overflow);
            end
         end
         if (n == 7) begin
            checks++;
            if (overflow !== 1'b1) begin
               errors++; $display("FAIL ovf_set: got %b want 1", overflow);
            end
         end
         transmit = (n == 0) || (n >= 2 && n <= 7);
         data_tx  = (n == 0) ? 8'hA0 : 8'(8'hAF + n);
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_sticky: got %b want 1", overflow);
      end
      checks++;
      if (busy_tx !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL ovf_end: got busy=%b full=%b want 0 0", busy_tx, full);
      end
   endtask

   // Asynchronous reset during DATA of 0xA5, then a clean 0x3C frame
   task automatic test_reset_mid_frame();
      logic e;
      do_reset();
      for (int n = 0; n <= 10; n++) begin
         @(negedge clk);
         if (n == 10) begin
            checks++;
            if (tx !== 1'b0) begin
               errors++; $display("FAIL rst_pre_tx: got %b want 0", tx);
            end
            checks++;
            if (overflow !== 1'b1) begin
               errors++; $display("FAIL rst_pre_ovf: got %b want 1", overflow);
            end
         end
         transmit = (n == 0) || (n >= 2 && n <= 6);
         data_tx  = (n == 0) ? 8'hA5 : 8'h11;
      end
      transmit = 1'b0;
      #2 nRst = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin
         errors++; $display("FAIL rst_async_tx: got %b want 1", tx);
      end
      checks++;
      if (busy_tx !== 1'b0) begin
         errors++; $display("FAIL rst_async_busy: got %b want 0", busy_tx);
      end
      checks++;
      if (overflow !== 1'b0 || full !== 1'b0) begin
         errors++; $display("FAIL rst_async_flags: got ovf=%b full=%b want 0 0", overflow, full);
      end
      @(negedge clk);
      nRst = 1'b1;
      exp_bytes[0] = 8'h3C;
      exp_n        = 1;
      for (int n = 0; n <= F + 2; n++) begin
         @(negedge clk);
         e = (n < 2) ? 1'b1 : stream_bit(n - 2, BAUD);
         checks++;
         if (tx !== e) begin
            errors++; $display("FAIL rst_after_tx n=%0d: got %b want %b", n, tx, e);
         end
         transmit = (n == 0);
         data_tx  = 8'h3C;
      end
      checks++;
      if (busy_tx !== 1'b0) begin
         errors++; $display("FAIL rst_after_busy: got %b want 0", busy_tx);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   // Even parity: 0x07 -> 1, 0x03 -> 0; frame of 44 cycles
   task automatic test_parity();
      logic [7:0] vec [2];
      logic       par [2];
      logic       e;
      vec[0] = 8'h07; par[0] = 1'b1;
      vec[1] = 8'h03; par[1] = 1'b0;
      for (int v = 0; v < 2; v++) begin
         exp_bytes[0] = vec[v];
         exp_n        = 1;
         for (int n = 0; n <= F + 2; n++) begin
            @(negedge clk);
            e = (n < 2) ? 1'b1 : stream_bit(n - 2, BAUD);
            checks++;
            if (tx !== e) begin
               errors++; $display("FAIL par_tx v=%0d n=%0d: got %b want %b", v, n, tx, e);
            end
            if (n == 2 + 9 * BAUD + 1) begin
               checks++;
               if (tx !== par[v]) begin
                  errors++; $display("FAIL par_bit v=%0d: got %b want %b", v, tx, par[v]);
               end
            end
            if (n == F + 1 || n == F + 2) begin
               e = (n == F + 1);
               checks++;
               if (busy_tx !== e) begin
                  errors++; $display("FAIL par_len v=%0d n=%0d: got %b want %b", v, n, busy_tx, e);
               end
            end
            transmit = (n == 0);
            data_tx  = vec[v];
         end
      end
   endtask
`endif

   // BAUD=434 instance: 0xFF frame, start bit exactly 434 cycles, frame 4340 (or 4774)
   task automatic test_slow_baud();
      logic e;
      exp_bytes[0] = 8'hFF;
      exp_n        = 1;
      for (int n = 0; n <= F_S + 2; n++) begin
         @(negedge clk);
         e = (n < 2) ? 1'b1 : stream_bit(n - 2, BAUD_S);
         checks++;
         if (tx_s !== e) begin
            errors++; $display("FAIL slow_tx n=%0d: got %b want %b", n, tx_s, e);
         end
         if (n == F_S + 1 || n == F_S + 2) begin
            e = (n == F_S + 1);
            checks++;
            if (busy_s !== e) begin
               errors++; $display("FAIL slow_busy n=%0d: got %b want %b", n, busy_s, e);
            end
         end
         transmit_s = (n == 0);
         data_s     = 8'hFF;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_slow_baud();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter: BAUD, 434, clk cycles per serial bit (115200 baud at 50 MHz); legal range 2..511.
REQ-002 SHALL have parameter: DEPTH_LOG2, 2, log2 of transmit FIFO depth (default 4 entries).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: nRst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: transmit  input  1  one-cycle request to queue data_tx.
REQ-006 SHALL have port: data_tx  input  8  byte to queue, sampled when transmit=1.
REQ-007 SHALL have port: busy_tx  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-008 SHALL have port: full  output  1  FIFO holds 2^DEPTH_LOG2 entries; combinational from FIFO count.
REQ-009 SHALL have port: overflow  output  1  sticky, set when transmit=1 while full=1.
REQ-010 SHALL have port: tx  output  1  serial line, registered, idle high.

Function
REQ-011 SHALL use frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit (see Configuration), 1 stop bit (1); each bit lasts exactly BAUD clk cycles.
REQ-012 SHALL write data_tx into the FIFO on a rising edge where transmit=1 and full=0; the write pointer wraps modulo 2^DEPTH_LOG2.
REQ-013 SHALL discard the byte and set overflow on an edge where transmit=1 and full=1, even if a pop occurs on the same edge; FIFO contents are unchanged.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; PARITY exists only when parity is compiled in.
REQ-015 SHALL, in IDLE with FIFO non-empty, pop the head entry into a shift register, drive tx=0 and enter START on the same edge.
REQ-016 SHALL therefore drive tx low on the edge after a write to an empty idle block (1-cycle latency from accept edge to start bit).
REQ-017 SHALL use a bit counter that counts 0..BAUD-1; on reaching BAUD-1 it clears and the FSM advances one bit.
REQ-018 SHALL transition START->DATA, DATA->DATA for bits 0..6, DATA->PARITY (or STOP) after bit 7, PARITY->STOP.
REQ-019 SHALL, at the end of STOP, pop the next entry and go directly to START if the FIFO is non-empty (no idle gap), else go to IDLE with tx=1.
REQ-020 SHALL allow a simultaneous push and pop when not full; the FIFO count is unchanged.
REQ-021 SHALL drive busy_tx = (state != IDLE) | (FIFO count != 0).
REQ-022 SHALL make tx glitch-free: driven only from a flop, updated only at bit boundaries.

Reset
REQ-023 SHALL, on nRst=0, asynchronously force tx=1, state=IDLE, bit counter=0, FIFO pointers and count=0, and overflow=0.
REQ-024 SHALL, on reset during a frame, abandon the frame immediately and return tx high with no stop bit completion.
REQ-025 SHALL leave FIFO data storage unreset; it is never read while empty.

Configuration
REQ-026 SHALL compile in a parity bit only when macro UART_TX_PARITY_EN is defined.
REQ-027 SHALL, with the macro defined, send even parity (XOR of the 8 data bits) after bit 7, making an 11-bit frame of 11*BAUD cycles.
REQ-028 SHALL, without the macro, omit the PARITY state entirely, giving a 10-bit frame of 10*BAUD cycles.

Verification (BAUD=4 unless stated)
REQ-029 SHALL cover: reset, then transmit=1 with data_tx=0x55 for one cycle -> tx low 1 cycle later; line shows 0,1,0,1,0,1,0,1,0,1 at 4 cycles each; busy_tx drops 40 cycles after the start bit.
REQ-030 SHALL cover: 5 back-to-back writes (0x01..0x05), depth 4, FIFO initially empty -> the first write is popped immediately, all 5 are accepted, and they appear on tx in order with no idle cycles between frames.
REQ-031 SHALL cover: writes on 6 consecutive cycles while a frame is in progress -> 4 accepted, full=1, overflow=1 after the 5th write, and only 4 bytes plus the in-progress byte are transmitted.
REQ-032 SHALL cover: with UART_TX_PARITY_EN defined and 0x07 sent -> parity bit 1, frame of 44 cycles; with 0x03 sent -> parity bit 0.
REQ-033 SHALL cover: nRst asserted mid-DATA of 0xA5 -> tx=1 in the same cycle (asynchronous), busy_tx=0, overflow=0, and a new 0x3C after release is sent correctly.
REQ-034 SHALL cover: BAUD=434 with a single 0xFF -> each bit lasts exactly 434 cycles and the frame lasts 4340 cycles.
